// File: rtl/julia_dispatcher.sv
// julia_dispatcher: host-side controller for one julia_worker.
// Sweeps every pixel of a frame in raster order, starts the worker on each pixel,
// collects its address/color result, writes it to the frame buffer through a
// write/waitrequest master and then releases the worker by dropping MC_busy.
// A watchdog abandons a pixel whose worker never answers and writes it black.
module julia_dispatcher #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int WIDTH   = 22,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [WIDTH-1:0] c_real_in,
    input  logic [WIDTH-1:0] c_imag_in,
    output logic             frame_busy,
    output logic             frame_done,
    output logic             timeout_err,
    output logic [9:0]       x,
    output logic [9:0]       y,
    output logic [WIDTH-1:0] c_real_out,
    output logic [WIDTH-1:0] c_imag_out,
    output logic             JW_start,
    input  logic             JW_ready,
    input  logic             JW_done,
    input  logic [31:0]      address,
    input  logic [31:0]      color,
    output logic             MC_busy,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_waitreq
);

    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [9:0]      X_LAST  = 10'(H_RES - 1);
    localparam logic [9:0]      Y_LAST  = 10'(V_RES - 1);
    localparam logic [31:0]     H_RES_W = 32'(H_RES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        START,
        WAIT_DONE,
        WRITE,
        ACK
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [WD_W-1:0] wd_count;
    logic            last_pixel;
    logic            wd_expired;
    logic [31:0]     pixel_offset;

    assign last_pixel   = (x == X_LAST) && (y == Y_LAST);
    assign wd_expired   = (wd_count == WD_LAST);
    // Byte address of the current pixel, used only when the worker never answered
    assign pixel_offset = (({22'd0, y} * H_RES_W) + {22'd0, x}) << 2;

    // State register; reset abandons any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the handshake strobes, which are pure functions of state
    always_comb begin
        next_state = state;
        JW_start   = 1'b0;
        mem_write  = 1'b0;
        MC_busy    = 1'b1;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    next_state = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (JW_ready) begin
                    next_state = START;
                end
            end
            START: begin
                JW_start   = 1'b1;
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (JW_done || wd_expired) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                if (!mem_waitreq) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                MC_busy    = 1'b0;
                next_state = last_pixel ? IDLE : WAIT_RDY;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Frame bookkeeping: constants, pixel counters, watchdog, captured result and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            c_real_out  <= '0;
            c_imag_out  <= '0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wd_count    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        c_real_out  <= c_real_in;
                        c_imag_out  <= c_imag_in;
                        timeout_err <= 1'b0;
                        x           <= '0;
                        y           <= '0;
                        frame_busy  <= 1'b1;
                    end
                end
                START: begin
                    wd_count <= '0;
                end
                WAIT_DONE: begin
                    if (JW_done) begin
                        mem_addr  <= address;
                        mem_wdata <= color;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        mem_addr    <= pixel_offset;
                        mem_wdata   <= '0;
                    end else begin
                        wd_count <= wd_count + WD_W'(1);
                    end
                end
                ACK: begin
                    if (last_pixel) begin
                        x          <= '0;
                        y          <= '0;
                        frame_busy <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (x == X_LAST) begin
                        x <= '0;
                        y <= y + 10'd1;
                    end else begin
                        x <= x + 10'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
